// File: rtl/tx_dma_manager.sv
// UART transmit DMA engine: streams bytes in [tx_src_start, tx_src_stop) from memory into a UART serializer.
// Latency: a fetch starts one cycle after IDLE sees room; its bytes are pushed one per cycle after tx_mem_ready.
//   The serializer moves one bit per tx_clk_posedge.
// Backpressure: a fetch of N bytes starts only when the byte FIFO has N free entries, so pushes never overflow.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   tx_en                       enable fetching (the serializer drains regardless)
//   tx_clk_posedge              baud tick; each tick advances the serial line one bit
//   tx_ptr_rst                  reload the pointer from tx_src_start and flush the FIFO
//   tx_src_start/tx_src_stop    byte range [start, stop); wraps modulo 2^M_WIDTH
//   tx_done                     stop reached, FIFO empty, line idle
//   tx_fifo_level               bytes currently buffered
//   tx_mem_*                    read port: req held until the one-cycle ready strobe
//   tx                          serial line: start bit 0, 8 data bits LSB first, stop bit 1
// Optional feature: define TX_DMA_CIRC_EN to add input tx_circ (circular buffer mode).
module tx_dma_manager #(
  parameter int         M_WIDTH    = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter int         MAX_ACC    = 2,
  parameter logic [1:0] MEM_ACC_8  = 2'b00,
  parameter logic [1:0] MEM_ACC_16 = 2'b01,
  parameter logic [1:0] MEM_ACC_32 = 2'b10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic                          tx_clk_posedge,
  input  logic                          tx_ptr_rst,
  input  logic [M_WIDTH-1:0]            tx_src_start,
  input  logic [M_WIDTH-1:0]            tx_src_stop,
`ifdef TX_DMA_CIRC_EN
  input  logic                          tx_circ,
`endif
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_level,
  input  logic [M_WIDTH-1:0]            tx_mem_data_in,
  input  logic                          tx_mem_ready,
  output logic                          tx_mem_req,
  output logic [M_WIDTH-1:0]            tx_mem_addr,
  output logic [1:0]                    tx_mem_width,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;

  state_t             state, state_nxt;
  logic [M_WIDTH-1:0] ptr, ptr_inc, rem;
  logic [LW-1:0]      level, free;
  logic [2:0]         n_sel, n_lat, push_cnt;
  logic [1:0]         width_sel;
  logic [31:0]        word;
  logic [7:0]         push_byte;
  logic               rst_pend;
  logic               start_fetch, reload, push, last_push, pop, wrap;
  logic               fifo_empty, circ_on;

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_idx, rd_idx;

  logic               ser_busy;
  logic [3:0]         bit_idx;
  logic [7:0]         shreg;
  logic               tx_q;

`ifdef TX_DMA_CIRC_EN
  assign circ_on = tx_circ;
`else
  assign circ_on = 1'b0;
`endif

  assign rem        = tx_src_stop - ptr;
  assign ptr_inc    = ptr + M_WIDTH'(1);
  assign free       = LW'(FIFO_DEPTH) - level;
  assign fifo_empty = (level == '0);
  // Fetches are clipped by rem, so reaching stop always coincides with the word's final byte.
  assign wrap       = circ_on && (ptr_inc == tx_src_stop);
  // Memory returns the aligned word; the byte for address A sits in lane A%4.
  assign push_byte  = word[{ptr[1:0], 3'b000} +: 8];

  // Widest aligned access that the remaining length and MAX_ACC allow.
  always_comb begin
    n_sel     = 3'd1;
    width_sel = MEM_ACC_8;
    if (MAX_ACC >= 2 && ptr[1:0] == 2'b00 && rem >= M_WIDTH'(4)) begin
      n_sel     = 3'd4;
      width_sel = MEM_ACC_32;
    end else if (MAX_ACC >= 1 && ptr[0] == 1'b0 && rem >= M_WIDTH'(2)) begin
      n_sel     = 3'd2;
      width_sel = MEM_ACC_16;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    reload      = 1'b0;
    push        = 1'b0;
    last_push   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_ptr_rst) begin
          reload = 1'b1;
        end else if (tx_en && ptr != tx_src_stop && free >= LW'(n_sel)) begin
          start_fetch = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        // A reload requested while the read is in flight waits for the read
        // to retire; the returned word is then dropped.
        if (tx_mem_ready) begin
          reload    = rst_pend || tx_ptr_rst;
          state_nxt = (rst_pend || tx_ptr_rst) ? IDLE : PUSH;
        end
      end
      PUSH: begin
        if (tx_ptr_rst) begin
          reload    = 1'b1;
          state_nxt = IDLE;
        end else begin
          push      = 1'b1;
          last_push = (push_cnt == n_lat - 3'd1) || wrap;
          if (last_push) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      n_lat        <= 3'd1;
      push_cnt     <= 3'd0;
      word         <= '0;
      rst_pend     <= 1'b0;
      tx_mem_req   <= 1'b0;
      tx_mem_addr  <= '0;
      tx_mem_width <= MEM_ACC_8;
    end else begin
      if (start_fetch) begin
        n_lat        <= n_sel;
        push_cnt     <= 3'd0;
        tx_mem_req   <= 1'b1;
        tx_mem_addr  <= ptr;
        tx_mem_width <= width_sel;
      end
      if (state == REQ) begin
        if (tx_ptr_rst) rst_pend <= 1'b1;
        if (tx_mem_ready) begin
          tx_mem_req <= 1'b0;
          word       <= tx_mem_data_in[31:0];
          rst_pend   <= 1'b0;
        end
      end
      if (reload) begin
        ptr <= tx_src_start;
      end else if (push) begin
        ptr      <= wrap ? tx_src_start : ptr_inc;
        push_cnt <= push_cnt + 3'd1;
      end
    end
  end

  // Byte FIFO; a reload flushes it and also blocks that cycle's pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      level  <= '0;
    end else if (reload) begin
      wr_idx <= '0;
      rd_idx <= '0;
      level  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + AW'(1);
      if (pop)  rd_idx <= rd_idx + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= push_byte;
  end

  // Serializer: a frame occupies 10 ticks (start, 8 data, stop). The next byte
  // is taken on the tick that ends the stop bit, so frames run back to back.
  assign pop = tx_clk_posedge && !fifo_empty && !reload && (!ser_busy || bit_idx == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_busy <= 1'b0;
      bit_idx  <= 4'd0;
      shreg    <= 8'd0;
      tx_q     <= 1'b1;
    end else if (tx_clk_posedge) begin
      if (pop) begin
        shreg    <= fifo_mem[rd_idx];
        bit_idx  <= 4'd0;
        tx_q     <= 1'b0;
        ser_busy <= 1'b1;
      end else if (ser_busy) begin
        if (bit_idx < 4'd8) begin
          tx_q    <= shreg[bit_idx[2:0]];
          bit_idx <= bit_idx + 4'd1;
        end else if (bit_idx == 4'd8) begin
          tx_q    <= 1'b1;
          bit_idx <= 4'd9;
        end else begin
          ser_busy <= 1'b0;
        end
      end
    end
  end

  assign tx            = tx_q;
  assign tx_fifo_level = level;
  assign tx_done       = tx_en && (ptr == tx_src_stop) && (state == IDLE) && !rst_pend &&
                         fifo_empty && !ser_busy && !circ_on;

endmodule

// File: tb/tb_tx_dma_manager.sv
// Directed bench for tx_dma_manager (FIFO_DEPTH=4, MAX_ACC=2): memory responder,
// UART receiver on tx, and a linear sequence of directed steps with immediate assertions.
module tb_tx_dma_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic        tx_clk_posedge;
  logic        tx_ptr_rst;
  logic [31:0] tx_src_start;
  logic [31:0] tx_src_stop;
  logic        tx_done;
  logic [2:0]  tx_fifo_level;
  logic [31:0] tx_mem_data_in;
  logic        tx_mem_ready;
  logic        tx_mem_req;
  logic [31:0] tx_mem_addr;
  logic [1:0]  tx_mem_width;
  logic        tx;
`ifdef TX_DMA_CIRC_EN
  logic        tx_circ;
`endif

  tx_dma_manager #(.M_WIDTH(32), .FIFO_DEPTH(4), .MAX_ACC(2)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_clk_posedge(tx_clk_posedge),
    .tx_ptr_rst(tx_ptr_rst), .tx_src_start(tx_src_start), .tx_src_stop(tx_src_stop),
`ifdef TX_DMA_CIRC_EN
    .tx_circ(tx_circ),
`endif
    .tx_done(tx_done), .tx_fifo_level(tx_fifo_level), .tx_mem_data_in(tx_mem_data_in),
    .tx_mem_ready(tx_mem_ready), .tx_mem_req(tx_mem_req), .tx_mem_addr(tx_mem_addr),
    .tx_mem_width(tx_mem_width), .tx(tx)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          tick_div = 1;
  logic        tick_en  = 1'b0;
  int          tick_cnt = 0;
  int          mem_delay = 0;
  int          max_level = 0;
  int          rx_phase = 0;
  logic [7:0]  rx_byte;
  logic        last_stop_done;
  logic [7:0]  rx_q[$];
  logic [31:0] req_addr_q[$];
  logic [1:0]  req_w_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents: 0x100..0x107 hold 0x11,0x22,...,0x88; injective over any 256-byte page.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] k;
    k = {4'h0, a[3:0]} + 8'd1;
    return (k * 8'h11) ^ {a[7:4], 4'h0};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_byte({a[31:2], 2'b00} + 32'(i));
    return w;
  endfunction

  // Baud tick generator.
  initial begin
    tx_clk_posedge = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      tx_clk_posedge = tick_en && (tick_cnt % tick_div == 0);
    end
  end

  // Memory responder; also checks that each fetch had room for all its bytes.
  initial begin
    int n;
    int free_now;
    tx_mem_ready   = 1'b0;
    tx_mem_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_mem_req && !rst) begin
        req_addr_q.push_back(tx_mem_addr);
        req_w_q.push_back(tx_mem_width);
        n = (tx_mem_width == 2'b10) ? 4 : (tx_mem_width == 2'b01) ? 2 : 1;
        free_now = 4 - int'(tx_fifo_level);
        check("fetch_room", 64'(free_now >= n), 64'd1);
        repeat (mem_delay) @(posedge clk);
        @(negedge clk);
        tx_mem_data_in = mem_word(tx_mem_addr);
        tx_mem_ready   = 1'b1;
        @(posedge clk);
        #1;
        tx_mem_ready = 1'b0;
      end
    end
  end

  // UART receiver, one sample per tick just after the serializer updates.
  initial begin
    forever begin
      @(posedge clk);
      if (tx_clk_posedge && !rst) begin
        #1;
        if (rx_phase == 0) begin
          if (tx === 1'b0) rx_phase = 1;
        end else if (rx_phase <= 8) begin
          rx_byte[rx_phase-1] = tx;
          rx_phase++;
        end else begin
          check("stop_bit", 64'(tx), 64'd1);
          last_stop_done = tx_done;
          rx_q.push_back(rx_byte);
          rx_phase = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (int'(tx_fifo_level) > max_level) max_level = int'(tx_fifo_level);
    end
  end

  task automatic load_buf(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    tx_en        = 1'b0;
    tx_src_start = s;
    tx_src_stop  = e;
    tx_ptr_rst   = 1'b1;
    @(negedge clk);
    tx_ptr_rst = 1'b0;
    rx_q.delete();
    req_addr_q.delete();
    req_w_q.delete();
    tx_en = 1'b1;
  endtask

  task automatic wait_done(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic       ok;
    logic       got;
    logic       dropped;
    logic       done_seen;
    int         mism;
    logic [7:0] exp1 [8];
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    rst = 1'b1; tx_en = 1'b0; tx_ptr_rst = 1'b0;
    tx_src_start = '0; tx_src_stop = '0;
`ifdef TX_DMA_CIRC_EN
    tx_circ = 1'b0;
`endif
    #1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req",   64'(tx_mem_req),    64'd0);
    check("rst_addr",  64'(tx_mem_addr),   64'd0);
    check("rst_width", 64'(tx_mem_width),  64'd0);
    check("rst_level", 64'(tx_fifo_level), 64'd0);
    check("rst_done",  64'(tx_done),       64'd0);
    check("rst_tx",    64'(tx),            64'd1);

    // Aligned 32-bit path.
    tick_div = 1; tick_en = 1'b1;
    load_buf(32'h100, 32'h108);
    wait_done(2000, ok);
    check("al_done", 64'(ok), 64'd1);
    check("al_nbytes", 64'(rx_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) check("al_byte", 64'(rx_q[i]), 64'(exp1[i]));
    check("al_done_at_last_stop", 64'(last_stop_done), 64'd0);
    check("al_nreq", 64'(req_addr_q.size()), 64'd2);
    if (req_addr_q.size() == 2) begin
      check("al_req0_addr", 64'(req_addr_q[0]), 64'h100);
      check("al_req0_w",    64'(req_w_q[0]),    64'd2);
      check("al_req1_addr", 64'(req_addr_q[1]), 64'h104);
      check("al_req1_w",    64'(req_w_q[1]),    64'd2);
    end

    // Unaligned path: 8@101, 16@102, 16@104, 8@106.
    load_buf(32'h101, 32'h107);
    wait_done(2000, ok);
    check("ua_done", 64'(ok), 64'd1);
    check("ua_nbytes", 64'(rx_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) check("ua_byte", 64'(rx_q[i]), 64'(exp1[i+1]));
    check("ua_nreq", 64'(req_addr_q.size()), 64'd4);
    if (req_addr_q.size() == 4) begin
      check("ua_req0", 64'({req_addr_q[0], 2'b00, req_w_q[0]}), 64'({32'h101, 4'h0}));
      check("ua_req1", 64'({req_addr_q[1], 2'b00, req_w_q[1]}), 64'({32'h102, 4'h1}));
      check("ua_req2", 64'({req_addr_q[2], 2'b00, req_w_q[2]}), 64'({32'h104, 4'h1}));
      check("ua_req3", 64'({req_addr_q[3], 2'b00, req_w_q[3]}), 64'({32'h106, 4'h0}));
    end

    // start == stop: immediate done, no traffic.
    @(negedge clk);
    tx_en = 1'b0; tx_src_start = 32'h200; tx_src_stop = 32'h200; tx_ptr_rst = 1'b1;
    @(negedge clk);
    tx_ptr_rst = 1'b0;
    req_addr_q.delete();
    #1;
    check("ss_done_off", 64'(tx_done), 64'd0);
    @(negedge clk);
    tx_en = 1'b1;
    #1;
    check("ss_done_on", 64'(tx_done), 64'd1);
    repeat (5) @(negedge clk);
    check("ss_nreq", 64'(req_addr_q.size()), 64'd0);

    // Backpressure: 64 bytes, slow ticks.
    tick_div = 3;
    max_level = 0;
    load_buf(32'h300, 32'h340);
    wait_done(5000, ok);
    check("bp_done", 64'(ok), 64'd1);
    check("bp_nbytes", 64'(rx_q.size()), 64'd64);
    mism = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== mem_byte(32'h300 + 32'(i))) mism++;
    check("bp_byte_errs", 64'(mism), 64'd0);
    check("bp_nreq", 64'(req_addr_q.size()), 64'd16);
    check("bp_max_level", 64'(max_level), 64'd4);

    // tx_ptr_rst while a slow read is outstanding.
    tick_en = 1'b0; tick_div = 1; mem_delay = 5;
    load_buf(32'h401, 32'h410);
    for (int i = 0; i < 100 && req_addr_q.size() < 2; i++) @(negedge clk);
    check("pr_second_req", 64'(req_addr_q.size()), 64'd2);
    check("pr_level_before", 64'(tx_fifo_level), 64'd1);
    tx_src_start = 32'h500; tx_src_stop = 32'h504; tx_ptr_rst = 1'b1;
    @(negedge clk);
    tx_ptr_rst = 1'b0;
    got = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (tx_mem_ready) begin
        got = 1'b1;
        break;
      end
      if (!tx_mem_req) dropped = 1'b1;
    end
    check("pr_ready_seen", 64'(got), 64'd1);
    check("pr_req_held", 64'(dropped), 64'd0);
    @(posedge clk);
    #2;
    check("pr_level_flushed", 64'(tx_fifo_level), 64'd0);
    check("pr_req_low", 64'(tx_mem_req), 64'd0);
    mem_delay = 0;
    tick_en = 1'b1;
    wait_done(2000, ok);
    check("pr_done", 64'(ok), 64'd1);
    check("pr_nbytes", 64'(rx_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) check("pr_byte", 64'(rx_q[i]), 64'(mem_byte(32'h500 + 32'(i))));
    check("pr_nreq", 64'(req_addr_q.size()), 64'd3);
    if (req_addr_q.size() == 3) begin
      check("pr_req2_addr", 64'(req_addr_q[2]), 64'h500);
      check("pr_req2_w",    64'(req_w_q[2]),    64'd2);
    end

    // Asynchronous reset in the middle of a push burst.
    tick_en = 1'b0;
    load_buf(32'h600, 32'h610);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (tx_mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("ar_ready_seen", 64'(got), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("ar_level_pre", 64'(tx_fifo_level), 64'd1);
    check("ar_addr_pre",  64'(tx_mem_addr),   64'h600);
    #1;
    rst = 1'b1;
    #1;
    check("ar_req",   64'(tx_mem_req),    64'd0);
    check("ar_addr",  64'(tx_mem_addr),   64'd0);
    check("ar_width", 64'(tx_mem_width),  64'd0);
    check("ar_level", 64'(tx_fifo_level), 64'd0);
    check("ar_done",  64'(tx_done),       64'd0);
    check("ar_tx",    64'(tx),            64'd1);
    tx_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

`ifdef TX_DMA_CIRC_EN
    // Circular mode over a 3-byte buffer.
    tick_en = 1'b1; tick_div = 1;
    tx_circ = 1'b1;
    load_buf(32'h700, 32'h703);
    done_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_done) done_seen = 1'b1;
      if (rx_q.size() >= 7) break;
    end
    check("ci_nbytes_min", 64'(rx_q.size() >= 7), 64'd1);
    check("ci_done_low", 64'(done_seen), 64'd0);
    tx_circ = 1'b0;
    wait_done(1000, ok);
    check("ci_done", 64'(ok), 64'd1);
    mism = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== mem_byte(32'h700 + 32'(i % 3))) mism++;
    check("ci_byte_errs", 64'(mism), 64'd0);
    check("ci_whole_laps", 64'(rx_q.size() % 3), 64'd0);
    if (rx_q.size() > 0) check("ci_last_is_c", 64'(rx_q[rx_q.size()-1]), 64'(mem_byte(32'h702)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
